// File: rtl/bus_mem.sv
// bus_mem: byte-wide RAM plus an I/O page at 0xFF00: console TX FIFO, status, optional timer and GPIO.
// Defining BUS_MEM_TIMER_EN adds the free-running 16-bit timer at FF02/FF03; otherwise those addresses read 0.
module bus_mem #(
    parameter int RAM_AW     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  gpio_out
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [4:0]        count;
    logic              overflow;
    logic              io, wr_io, full, empty, push, pop, accept;
    logic [7:0]        stat, io_rdata, timer_lo, timer_hi;
    logic [RAM_AW-1:0] ram_addr;

    assign io       = address[15:8] == 8'hFF;
    assign wr_io    = !read && io;
    assign ram_addr = address[RAM_AW-1:0];
    assign full     = count == 5'(FIFO_DEPTH);
    assign empty    = count == 5'd0;
    assign tx_valid = !empty;
    assign tx_data  = fifo[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push     = wr_io && address[7:0] == 8'h00;
    // a push into a full FIFO still lands when a pop frees the slot in the same cycle
    assign accept   = push && (!full || pop);
    assign stat     = {overflow, count, empty, full};

`ifdef BUS_MEM_TIMER_EN
    logic [15:0] timer;
    logic [7:0]  snap;

    // free-running counter; reading the low byte freezes the high byte for a later FF03 read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 16'd0;
            snap  <= 8'd0;
        end else begin
            timer <= (wr_io && address[7:0] == 8'h02) ? 16'd0 : timer + 16'd1;
            if (read && io && address[7:0] == 8'h02) snap <= timer[15:8];
        end
    end

    assign timer_lo = timer[7:0];
    assign timer_hi = snap;
`else
    assign timer_lo = 8'h00;
    assign timer_hi = 8'h00;
`endif

    // I/O page read mux; console data and unused addresses read as zero
    always_comb begin
        io_rdata = address[7:0] == 8'h01 ? stat :
                   address[7:0] == 8'h02 ? timer_lo :
                   address[7:0] == 8'h03 ? timer_hi :
                   address[7:0] == 8'h04 ? gpio_out : 8'h00;
    end

    // RAM is never initialised; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst && !read && !io) ram[ram_addr] <= wdata;
    end

    // registered read data, held across write cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= 8'h00;
        else if (read) rdata <= io ? io_rdata : ram[ram_addr];
    end

    // console FIFO: storage is cleared on reset so tx_data reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                fifo[wr_ptr] <= wdata;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count    <= count + 5'(accept) - 5'(pop);
            overflow <= (wr_io && address[7:0] == 8'h01) ? 1'b0 :
                        (push && !accept) ? 1'b1 : overflow;
        end
    end

    // general-purpose output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) gpio_out <= 8'h00;
        else if (wr_io && address[7:0] == 8'h04) gpio_out <= wdata;
    end
endmodule

// File: tb/tb_bus_mem.sv
// tb_bus_mem: table vectors, corner sequences and random traffic against a queue-based model of bus_mem.
module tb_bus_mem;
    localparam int AW = 12;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b1;
    logic        tx_ready = 1'b0;
    logic [15:0] address = 16'hFF05;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata, tx_data, gpio_out;
    logic        tx_valid;

    bus_mem #(.RAM_AW(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .read(read), .address(address), .wdata(wdata),
        .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // behavioural model state
    logic [7:0]  mram [0:(1<<AW)-1];
    bit          mval [0:(1<<AW)-1];
    logic [7:0]  q[$];
    bit          movf, mknown;
    logic [7:0]  mgpio, mrd, msnap;
    logic [15:0] mtim;

    task automatic model_reset();
        q.delete();
        movf = 0; mknown = 1; mgpio = 0; mrd = 0; msnap = 0; mtim = 0;
    endtask

    // one bus cycle: drive, advance model, clock, compare
    task automatic step(input logic rd, input logic [15:0] a, input logic [7:0] wd, input logic rdy);
        bit io, pop, ok;
        int n;
        logic [7:0] r, stat;
        read = rd; address = a; wdata = wd; tx_ready = rdy;
        io = a[15:8] == 8'hFF;
        r = a[7:0];
        n = q.size();
        pop = (n != 0) && rdy;
        stat = {movf, 5'(n), n == 0, n == D};
        ok = 0;
        if (rd) begin
            if (!io) begin
                mknown = mval[a[AW-1:0]];
                mrd = mram[a[AW-1:0]];
            end else begin
                mknown = 1;
                case (r)
                    8'h01: mrd = stat;
                    8'h04: mrd = mgpio;
`ifdef BUS_MEM_TIMER_EN
                    8'h02: begin mrd = mtim[7:0]; msnap = mtim[15:8]; end
                    8'h03: mrd = msnap;
`endif
                    default: mrd = 8'h00;
                endcase
            end
        end else begin
            if (!io) begin
                mram[a[AW-1:0]] = wd;
                mval[a[AW-1:0]] = 1;
            end else if (r == 8'h00) begin
                ok = (n < D) || pop;
                if (!ok) movf = 1;
            end else if (r == 8'h01) movf = 0;
            else if (r == 8'h04) mgpio = wd;
        end
        if (pop) void'(q.pop_front());
        if (ok) q.push_back(wd);
`ifdef BUS_MEM_TIMER_EN
        mtim = (!rd && io && r == 8'h02) ? 16'h0000 : mtim + 16'h0001;
`endif
        @(posedge clk);
        #1;
        if (mknown) chk("rdata", rdata, mrd);
        chk("tx_valid", tx_valid, q.size() != 0);
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        chk("gpio_out", gpio_out, mgpio);
    endtask

    typedef struct {
        logic        rd;
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rdy;
        logic        c;
        logic [7:0]  exp;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] dq [4];
    logic [7:0] lo, hi;

    initial begin
        tbl[0]  = '{1'b0, 16'h0123, 8'h5A, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 16'h0123, 8'h00, 1'b0, 1'b1, 8'h5A};
        tbl[2]  = '{1'b1, 16'h1123, 8'h00, 1'b0, 1'b1, 8'h5A};
        tbl[3]  = '{1'b0, 16'hFF00, 8'h41, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 16'hFF00, 8'h42, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 16'hFF00, 8'h43, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 16'hFF00, 8'h44, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 16'hFF00, 8'h45, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 16'hFF01, 8'h00, 1'b0, 1'b1, 8'h91};
        tbl[9]  = '{1'b1, 16'hFF00, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 16'hFF00, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[11] = '{1'b1, 16'hFF00, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[12] = '{1'b1, 16'hFF00, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[13] = '{1'b1, 16'hFF01, 8'h00, 1'b1, 1'b1, 8'h82};
        tbl[14] = '{1'b0, 16'hFF01, 8'hFF, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b1, 16'hFF01, 8'h00, 1'b0, 1'b1, 8'h02};
        tbl[16] = '{1'b0, 16'hFF04, 8'h3C, 1'b0, 1'b0, 8'h00};
        tbl[17] = '{1'b1, 16'hFF04, 8'h00, 1'b0, 1'b1, 8'h3C};
        tbl[18] = '{1'b1, 16'hFF06, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[19] = '{1'b1, 16'hFF07, 8'h00, 1'b0, 1'b1, 8'h00};
        dq = '{8'h22, 8'h33, 8'h44, 8'h55};

        // reset state, held asynchronously before any clock edge
        #2;
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_gpio", gpio_out, 8'h00);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();

        // directed vectors: RAM alias, FIFO fill/overflow, drain, status, GPIO, unused I/O
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].rdy);
            if (tbl[i].c) chk($sformatf("vec%0d", i), rdata, tbl[i].exp);
        end

        // simultaneous push and pop while full
        for (int i = 0; i < 4; i++) step(1'b0, 16'hFF00, 8'(8'h11 * (i + 1)), 1'b0);
        step(1'b0, 16'hFF00, 8'h55, 1'b1);
        step(1'b1, 16'hFF01, 8'h00, 1'b0);
        chk("pushpop_stat", rdata, 8'h11);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pushpop_order%0d", i), tx_data, dq[i]);
            step(1'b1, 16'hFF05, 8'h00, 1'b1);
        end
        chk("pushpop_drained", tx_valid, 1'b0);

`ifdef BUS_MEM_TIMER_EN
        // FF02 read at counter 0x00FF; snapshot must not see the carry into the high byte
        step(1'b0, 16'hFF02, 8'h00, 1'b0);
        repeat (255) step(1'b1, 16'hFF05, 8'h00, 1'b0);
        step(1'b1, 16'hFF02, 8'h00, 1'b0);
        lo = rdata;
        step(1'b1, 16'hFF03, 8'h00, 1'b0);
        hi = rdata;
        chk("timer_snapshot", {hi, lo}, 16'h00FF);
`else
        step(1'b0, 16'hFF02, 8'h77, 1'b0);
        step(1'b1, 16'hFF02, 8'h00, 1'b0);
        chk("timer_l_off", rdata, 8'h00);
        step(1'b1, 16'hFF03, 8'h00, 1'b0);
        chk("timer_h_off", rdata, 8'h00);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 1) == 1) a = {4'($urandom), 6'h00, 6'($urandom)};
            else a = {8'hFF, 5'h00, 3'($urandom)};
            step(1'($urandom), a, 8'($urandom), 1'($urandom));
        end

        // asynchronous reset mid-burst
        step(1'b0, 16'h0200, 8'h11, 1'b0);
        step(1'b0, 16'hFF00, 8'h61, 1'b0);
        step(1'b0, 16'hFF00, 8'h62, 1'b0);
        step(1'b0, 16'hFF04, 8'h5A, 1'b0);
        step(1'b1, 16'h0200, 8'h00, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_rdata", rdata, 8'h00);
        chk("async_tx_valid", tx_valid, 1'b0);
        chk("async_tx_data", tx_data, 8'h00);
        chk("async_gpio", gpio_out, 8'h00);
        read = 1'b0; address = 16'h0200; wdata = 8'h99;
        @(posedge clk);
        #1;
        address = 16'hFF04; wdata = 8'h77;
        @(posedge clk);
        #1;
        chk("rst_write_ignored", gpio_out, 8'h00);
        read = 1'b1; address = 16'hFF05;
        #2 rst = 1'b1;
        model_reset();
        step(1'b1, 16'h0200, 8'h00, 1'b0);
        chk("rst_ram_write_ignored", rdata, 8'h11);
        step(1'b0, 16'hFF04, 8'hA5, 1'b0);
        chk("gpio_after_reset", gpio_out, 8'hA5);
        step(1'b1, 16'hFF01, 8'h00, 1'b0);
        chk("stat_after_reset", rdata, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
